// File: rtl/data_sram_bridge_if.sv
// Request/response and SRAM pin bundle for the data SRAM bridge.
// The master modport is the side that issues requests and returns SRAM read
// data (MEM stage plus the SRAM device); the slave modport is the bridge itself.
interface data_sram_bridge_if #(
    parameter int SRAM_AW = 20
);
    // MEM-stage request side
    logic                req_read;
    logic                req_write;
    logic [31:0]         req_addr;
    logic [31:0]         req_wdata;
    logic [1:0]          req_sel;
    logic                req_unsigned;
    logic                stall;
    logic [31:0]         rdata;
    logic                rdata_valid;
    logic                addr_err;

    // External SRAM side
    logic                sram_ce_n;
    logic                sram_oe_n;
    logic                sram_we_n;
    logic [3:0]          sram_be_n;
    logic [SRAM_AW-1:0]  sram_addr;
    logic [31:0]         sram_wdata;
    logic [31:0]         sram_rdata;

    modport master (
        output req_read, req_write, req_addr, req_wdata, req_sel, req_unsigned,
        output sram_rdata,
        input  stall, rdata, rdata_valid, addr_err,
        input  sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_wdata
    );

    modport slave (
        input  req_read, req_write, req_addr, req_wdata, req_sel, req_unsigned,
        input  sram_rdata,
        output stall, rdata, rdata_valid, addr_err,
        output sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_addr, sram_wdata
    );
endinterface

// File: rtl/data_sram_bridge.sv
// Multi-cycle bridge between the CPU MEM stage and a synchronous 32-bit data
// SRAM. One load/store per access; stall is held until the access completes.
// Handles byte-lane enables, store-data replication and load extension.
module data_sram_bridge #(
    parameter int SRAM_AW     = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    data_sram_bridge_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [1:0] SEL_WORD = 2'b00;
    localparam logic [1:0] SEL_HALF = 2'b01;
    localparam logic [1:0] SEL_BYTE = 2'b10;
    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t               state, state_nxt;
    logic [3:0]           cnt;
    logic [SRAM_AW-1:0]   addr_q;
    logic [1:0]           addr_lo_q;
    logic [1:0]           sel_q;
    logic                 unsigned_q;
    logic                 is_read_q;
    logic [3:0]           be_q;
    logic [31:0]          wdata_q;
    logic [31:0]          rdata_q;
    logic                 addr_err_q;

    logic                 request;
    logic                 conflict;
    logic                 misaligned;
    logic                 good_req;
    logic                 bad_req;
    logic [3:0]           be_nxt;
    logic [31:0]          wdata_nxt;
    logic [31:0]          load_ext;
    logic                 stall_c;

    // Address bits above the SRAM window are intentionally ignored.
    logic                 unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:SRAM_AW+2];

    // Request classification; reserved sel 11 behaves as a word access.
    always_comb begin
        request    = bus.req_read | bus.req_write;
        conflict   = bus.req_read & bus.req_write;
        misaligned = 1'b0;
        case (bus.req_sel)
            SEL_HALF: misaligned = bus.req_addr[0];
            SEL_BYTE: misaligned = 1'b0;
            default:  misaligned = (bus.req_addr[1:0] != 2'b00);
        endcase
        good_req = request & ~conflict & ~misaligned;
        bad_req  = request & (conflict | misaligned);
    end

    // Lane-positioned byte enables and replicated store data for a new request.
    always_comb begin
        be_nxt    = 4'b0000;
        wdata_nxt = bus.req_wdata;
        case (bus.req_sel)
            SEL_HALF: begin
                be_nxt    = bus.req_addr[1] ? 4'b0011 : 4'b1100;
                wdata_nxt = {2{bus.req_wdata[15:0]}};
            end
            SEL_BYTE: begin
                be_nxt    = ~(4'b0001 << bus.req_addr[1:0]);
                wdata_nxt = {4{bus.req_wdata[7:0]}};
            end
            default: begin
                be_nxt    = 4'b0000;
                wdata_nxt = bus.req_wdata;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the SRAM read word.
    always_comb begin
        load_ext = bus.sram_rdata;
        case (sel_q)
            SEL_HALF: begin
                logic [15:0] h;
                h        = addr_lo_q[1] ? bus.sram_rdata[31:16] : bus.sram_rdata[15:0];
                load_ext = {{16{h[15] & ~unsigned_q}}, h};
            end
            SEL_BYTE: begin
                logic [7:0] b;
                b        = bus.sram_rdata[8*addr_lo_q +: 8];
                load_ext = {{24{b[7] & ~unsigned_q}}, b};
            end
            default: load_ext = bus.sram_rdata;
        endcase
    end

    // Next-state and stall decode.
    // NOTE: every output of this block gets a default first so no path leaves
    // it unassigned; a missed branch would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                stall_c   = good_req;
                state_nxt = good_req ? ACCESS : IDLE;
            end
            ACCESS: begin
                stall_c   = 1'b1;
                state_nxt = (cnt == 4'd0) ? DONE : ACCESS;
            end
            DONE: begin
                stall_c   = 1'b0;
                state_nxt = IDLE;
            end
            default: begin
                stall_c   = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    // State register, request latch, wait counter and load capture.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            addr_q     <= '0;
            addr_lo_q  <= 2'b00;
            sel_q      <= SEL_WORD;
            unsigned_q <= 1'b0;
            is_read_q  <= 1'b0;
            be_q       <= 4'hF;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr_err_q <= (state == IDLE) && bad_req;
            if (state == IDLE && good_req) begin
                cnt        <= CNT_INIT;
                addr_q     <= bus.req_addr[SRAM_AW+1:2];
                addr_lo_q  <= bus.req_addr[1:0];
                sel_q      <= bus.req_sel;
                unsigned_q <= bus.req_unsigned;
                is_read_q  <= bus.req_read;
                be_q       <= be_nxt;
                wdata_q    <= wdata_nxt;
            end else if (state == ACCESS) begin
                if (cnt == 4'd0) begin
                    if (is_read_q) begin
                        rdata_q <= load_ext;
                    end
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end
        end
    end

    assign bus.stall       = stall_c;
    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = (state == DONE) && is_read_q;
    assign bus.addr_err    = addr_err_q;
    assign bus.sram_ce_n   = ~(state == ACCESS);
    assign bus.sram_oe_n   = ~((state == ACCESS) && is_read_q);
    assign bus.sram_we_n   = ~((state == ACCESS) && !is_read_q);
    assign bus.sram_be_n   = (state == ACCESS) ? be_q : 4'hF;
    assign bus.sram_addr   = addr_q;
    assign bus.sram_wdata  = wdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Self-checking bench for data_sram_bridge: two instances (WAIT_CYCLES=2 and 1)
// share one stimulus set; expected SRAM transactions and load results are
// queued when a request is driven and compared when the DUT produces them.
module tb_data_sram_bridge;

    typedef struct {
        logic        is_load;
        logic [19:0] addr;
        logic [3:0]  be_n;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [1:0]  req_sel = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] srd = 32'd0;
    logic        use_b = 1'b0;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    data_sram_bridge_if #(.SRAM_AW(20)) bus_a ();
    data_sram_bridge_if #(.SRAM_AW(20)) bus_b ();

    assign bus_a.req_read = req_read;     assign bus_b.req_read = req_read;
    assign bus_a.req_write = req_write;   assign bus_b.req_write = req_write;
    assign bus_a.req_addr = req_addr;     assign bus_b.req_addr = req_addr;
    assign bus_a.req_wdata = req_wdata;   assign bus_b.req_wdata = req_wdata;
    assign bus_a.req_sel = req_sel;       assign bus_b.req_sel = req_sel;
    assign bus_a.req_unsigned = req_unsigned;
    assign bus_b.req_unsigned = req_unsigned;
    assign bus_a.sram_rdata = srd;        assign bus_b.sram_rdata = srd;

    data_sram_bridge #(.SRAM_AW(20), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    data_sram_bridge #(.SRAM_AW(20), .WAIT_CYCLES(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    // Observed outputs of whichever instance the current test targets
    logic        o_stall, o_rvalid, o_err, o_ce_n, o_oe_n, o_we_n;
    logic [3:0]  o_be_n;
    logic [19:0] o_addr;
    logic [31:0] o_wdata, o_rdata;
    assign o_stall  = use_b ? bus_b.stall       : bus_a.stall;
    assign o_rvalid = use_b ? bus_b.rdata_valid : bus_a.rdata_valid;
    assign o_err    = use_b ? bus_b.addr_err    : bus_a.addr_err;
    assign o_ce_n   = use_b ? bus_b.sram_ce_n   : bus_a.sram_ce_n;
    assign o_oe_n   = use_b ? bus_b.sram_oe_n   : bus_a.sram_oe_n;
    assign o_we_n   = use_b ? bus_b.sram_we_n   : bus_a.sram_we_n;
    assign o_be_n   = use_b ? bus_b.sram_be_n   : bus_a.sram_be_n;
    assign o_addr   = use_b ? bus_b.sram_addr   : bus_a.sram_addr;
    assign o_wdata  = use_b ? bus_b.sram_wdata  : bus_a.sram_wdata;
    assign o_rdata  = use_b ? bus_b.rdata       : bus_a.rdata;

    // Reference model of lane enables, store replication and load extension
    function automatic logic [3:0] model_be(input logic [1:0] a, input logic [1:0] sel);
        case (sel)
            2'b01:   return a[1] ? 4'b0011 : 4'b1100;
            2'b10:   case (a)
                         2'd0: return 4'b1110;
                         2'd1: return 4'b1101;
                         2'd2: return 4'b1011;
                         default: return 4'b0111;
                     endcase
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] d, input logic [1:0] sel);
        case (sel)
            2'b01:   return {d[15:0], d[15:0]};
            2'b10:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] sel, input logic uns);
        logic [15:0] h;
        logic [7:0]  b;
        case (sel)
            2'b01: begin
                h = a[1] ? w[31:16] : w[15:0];
                return (uns || !h[15]) ? {16'h0000, h} : {16'hFFFF, h};
            end
            2'b10: begin
                case (a)
                    2'd0: b = w[7:0];
                    2'd1: b = w[15:8];
                    2'd2: b = w[23:16];
                    default: b = w[31:24];
                endcase
                return (uns || !b[7]) ? {24'h0, b} : {24'hFFFFFF, b};
            end
            default: return w;
        endcase
    endfunction

    task automatic idle_bus();
        req_read = 1'b0;
        req_write = 1'b0;
    endtask

    // Issue one legal request (caller is at posedge+1) and follow it to DONE.
    // Returns at posedge+1 of the cycle after DONE with the request still held.
    task automatic do_access(input string name, input logic rd, input logic [31:0] addr,
                             input logic [1:0] sel, input logic uns, input logic [31:0] wdata,
                             input logic [31:0] sram_word, input int wait_n);
        exp_t e, got;
        int   stall_cnt, strobe_cnt, done_at;
        bit   popped;
        e.is_load = rd;
        e.addr    = addr[21:2];
        e.be_n    = model_be(addr[1:0], sel);
        e.wdata   = model_wdata(wdata, sel);
        e.rdata   = model_load(sram_word, addr[1:0], sel, uns);
        sb.push_back(e);
        req_read = rd; req_write = !rd; req_addr = addr; req_sel = sel;
        req_unsigned = uns; req_wdata = wdata; srd = sram_word;
        stall_cnt = 0; strobe_cnt = 0; done_at = -1; popped = 1'b0;
        for (int c = 0; c < 40 && done_at < 0; c++) begin
            @(negedge clk);
            if (o_stall) stall_cnt++;
            if (!o_ce_n) begin
                strobe_cnt++;
                checks++;
                if (o_oe_n !== !rd || o_we_n !== rd) begin
                    errors++;
                    $display("FAIL %s strobe_dir: oe_n=%b we_n=%b want oe_n=%b we_n=%b",
                             name, o_oe_n, o_we_n, !rd, rd);
                end
                if (!popped) begin
                    popped = 1'b1;
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL %s sb_empty: strobe with no queued request", name);
                    end else begin
                        got = sb.pop_front();
                        checks++;
                        if (o_addr !== got.addr || o_be_n !== got.be_n ||
                            (!rd && o_wdata !== got.wdata)) begin
                            errors++;
                            $display("FAIL %s sram_bus: addr=%h be_n=%b wdata=%h want addr=%h be_n=%b wdata=%h",
                                     name, o_addr, o_be_n, o_wdata, got.addr, got.be_n, got.wdata);
                        end
                    end
                end
            end
            if (c > 0 && !o_stall) begin
                done_at = c;
                if (rd) begin
                    checks++;
                    if (o_rvalid !== 1'b1 || o_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL %s load_data: valid=%b rdata=%h want valid=1 rdata=%h",
                                 name, o_rvalid, o_rdata, e.rdata);
                    end
                end else begin
                    checks++;
                    if (o_rvalid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s store_valid: rdata_valid=%b want 0", name, o_rvalid);
                    end
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done_at != wait_n + 1 || stall_cnt != wait_n + 1 || strobe_cnt != wait_n) begin
            errors++;
            $display("FAIL %s timing: done_at=%0d stall=%0d strobes=%0d want %0d/%0d/%0d",
                     name, done_at, stall_cnt, strobe_cnt, wait_n + 1, wait_n + 1, wait_n);
        end
    endtask

    // Drive a request that must be rejected for exactly one cycle
    task automatic reject(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [1:0] sel);
        req_read = rd; req_write = wr; req_addr = addr; req_sel = sel;
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b0 || o_ce_n !== 1'b1 || o_err !== 1'b0) begin
            errors++;
            $display("FAIL %s req_cycle: stall=%b ce_n=%b addr_err=%b want 0/1/0",
                     name, o_stall, o_ce_n, o_err);
        end
        @(posedge clk); #1;
        idle_bus();
        @(negedge clk);
        checks++;
        if (o_err !== 1'b1 || o_stall !== 1'b0 || o_ce_n !== 1'b1 || o_be_n !== 4'hF) begin
            errors++;
            $display("FAIL %s err_pulse: addr_err=%b stall=%b ce_n=%b be_n=%b want 1/0/1/F",
                     name, o_err, o_stall, o_ce_n, o_be_n);
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_err !== 1'b0 || o_ce_n !== 1'b1) begin
            errors++;
            $display("FAIL %s err_end: addr_err=%b ce_n=%b want 0/1", name, o_err, o_ce_n);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            use_b = (k == 1);
            @(negedge clk);
            checks++;
            if (o_stall !== 1'b0 || o_rvalid !== 1'b0 || o_err !== 1'b0 || o_rdata !== 32'd0 ||
                o_ce_n !== 1'b1 || o_oe_n !== 1'b1 || o_we_n !== 1'b1 || o_be_n !== 4'hF ||
                o_addr !== 20'd0 || o_wdata !== 32'd0) begin
                errors++;
                $display("FAIL reset_state[%0d]: stall=%b rv=%b err=%b rdata=%h ce=%b oe=%b we=%b be=%b addr=%h wd=%h",
                         k, o_stall, o_rvalid, o_err, o_rdata, o_ce_n, o_oe_n, o_we_n,
                         o_be_n, o_addr, o_wdata);
            end
        end
        use_b = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_access();
        use_b = 1'b0;
        req_read = 1'b1; req_addr = 32'h0000_0300; req_sel = 2'b00; srd = 32'h1234_5678;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (o_ce_n !== 1'b0 || o_stall !== 1'b1) begin
            errors++;
            $display("FAIL mid_access_entry: ce_n=%b stall=%b want 0/1", o_ce_n, o_stall);
        end
        rst = 1'b0;
        idle_bus();
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_stall !== 1'b0 || o_ce_n !== 1'b1 || o_oe_n !== 1'b1 || o_we_n !== 1'b1 ||
            o_be_n !== 4'hF || o_rvalid !== 1'b0 || o_addr !== 20'd0) begin
            errors++;
            $display("FAIL reset_mid_access: stall=%b ce=%b oe=%b we=%b be=%b rv=%b addr=%h want 0/1/1/1/F/0/0",
                     o_stall, o_ce_n, o_oe_n, o_we_n, o_be_n, o_rvalid, o_addr);
        end
        @(posedge clk); #1;
        // A fresh access must then run the full sequence
        do_access("post_reset_load", 1'b1, 32'h0000_0300, 2'b00, 1'b0, 32'd0, 32'h1234_5678, 2);
        idle_bus();
    endtask

    task automatic test_word_store();
        use_b = 1'b0;
        do_access("word_store", 1'b0, 32'h0000_0100, 2'b00, 1'b0, 32'hDEAD_BEEF, 32'd0, 2);
        idle_bus();
        checks++;
        if (o_addr !== 20'h00040) begin
            errors++;
            $display("FAIL word_store_addr: sram_addr=%h want 00040", o_addr);
        end
    endtask

    task automatic test_byte_load();
        use_b = 1'b0;
        do_access("byte_load_signed", 1'b1, 32'h0000_0103, 2'b10, 1'b0, 32'd0, 32'h80FF_1234, 2);
        idle_bus();
        do_access("byte_load_unsigned", 1'b1, 32'h0000_0103, 2'b10, 1'b1, 32'd0, 32'h80FF_1234, 2);
        idle_bus();
        do_access("half_load_signed", 1'b1, 32'h0000_0102, 2'b01, 1'b0, 32'd0, 32'h80FF_1234, 2);
        idle_bus();
        srd = 32'h5555_5555;
        @(negedge clk);
        checks++;
        if (o_rdata !== 32'hFFFF_80FF || o_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rdata_hold: rdata=%h valid=%b want ffff80ff/0", o_rdata, o_rvalid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_half_store();
        use_b = 1'b0;
        do_access("half_store", 1'b0, 32'h0000_0022, 2'b01, 1'b0, 32'h0000_ABCD, 32'd0, 2);
        idle_bus();
        do_access("byte_store_lane1", 1'b0, 32'h0000_0041, 2'b10, 1'b0, 32'h0000_0077, 32'd0, 2);
        idle_bus();
    endtask

    task automatic test_reject();
        use_b = 1'b0;
        reject("misaligned_half", 1'b1, 1'b0, 32'h0000_0021, 2'b01);
        reject("misaligned_word", 1'b1, 1'b0, 32'h0000_0102, 2'b00);
        reject("rw_conflict", 1'b1, 1'b1, 32'h0000_0100, 2'b00);
    endtask

    task automatic test_back_to_back();
        use_b = 1'b1;
        do_access("b2b_first", 1'b1, 32'h0000_0200, 2'b00, 1'b0, 32'd0, 32'h1122_3344, 1);
        do_access("b2b_second", 1'b1, 32'h0000_0206, 2'b01, 1'b1, 32'd0, 32'hCAFE_0000, 1);
        idle_bus();
        @(negedge clk);
        checks++;
        if (o_ce_n !== 1'b1 || o_stall !== 1'b0 || o_rdata !== 32'h0000_CAFE) begin
            errors++;
            $display("FAIL b2b_no_dup: ce_n=%b stall=%b rdata=%h want 1/0/0000cafe",
                     o_ce_n, o_stall, o_rdata);
        end
        @(posedge clk); #1;
        use_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_word_store();
        test_byte_load();
        test_half_store();
        test_reject();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
